// File: rtl/pid_pkg.sv
// Shared constants and types for the PID sequencer and its coefficient bank.
package pid_pkg;

    localparam int PID_NSTATES   = 8;
    localparam int PID_STATE_OUT = 7;
    localparam int PID_SW        = $clog2(PID_NSTATES);
    localparam int PID_CW        = 6;

    // Coefficient select encoding on the configuration bus.
    typedef enum logic [1:0] {
        SEL_KP   = 2'd0,
        SEL_KI   = 2'd1,
        SEL_KD   = 2'd2,
        SEL_NONE = 2'd3
    } pid_sel_e;

    // Signed shift amount as stored in the coefficient banks.
    typedef logic signed [PID_CW-1:0] pid_coef_t;

endpackage

// File: rtl/pid_coef_bank.sv
// Per-channel KP/KI/KD storage: a shadow bank written by the bus and an
// active bank read by the datapath, copied across only on commit.
module pid_coef_bank
    import pid_pkg::*;
#(
    parameter int aw     = 1,
    parameter int cw     = PID_CW,
    parameter int KP_DEF = 1,
    parameter int KI_DEF = 0,
    parameter int KD_DEF = 0
) (
    input  logic                 clk_pid,
    input  logic                 reset_n,
    input  logic                 we_i,
    input  logic [aw-1:0]        ch_i,
    input  logic [1:0]           sel_i,
    input  logic signed [cw-1:0] data_i,
    input  logic                 commit_i,
    input  logic [aw-1:0]        rd_ch_i,
    output logic signed [cw-1:0] kp_o,
    output logic signed [cw-1:0] ki_o,
    output logic signed [cw-1:0] kd_o,
    output logic                 pending_o
);

    localparam int AN = 1 << aw;

    logic signed [cw-1:0] kp_sh_q [AN];
    logic signed [cw-1:0] ki_sh_q [AN];
    logic signed [cw-1:0] kd_sh_q [AN];
    logic signed [cw-1:0] kp_ac_q [AN];
    logic signed [cw-1:0] ki_ac_q [AN];
    logic signed [cw-1:0] kd_ac_q [AN];
    logic                 pending_q;

    // Shadow writes, active-bank commit and the pending flag.
    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: both banks are reset element by element because the
            // default coefficients are visible to the datapath right after reset.
            for (int i = 0; i < AN; i++) begin
                kp_sh_q[i] <= cw'(KP_DEF);
                ki_sh_q[i] <= cw'(KI_DEF);
                kd_sh_q[i] <= cw'(KD_DEF);
                kp_ac_q[i] <= cw'(KP_DEF);
                ki_ac_q[i] <= cw'(KI_DEF);
                kd_ac_q[i] <= cw'(KD_DEF);
            end
            pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the commit copy the shadow
            // values from before a write landing in the same cycle.
            if (commit_i && pending_q) begin
                for (int i = 0; i < AN; i++) begin
                    kp_ac_q[i] <= kp_sh_q[i];
                    ki_ac_q[i] <= ki_sh_q[i];
                    kd_ac_q[i] <= kd_sh_q[i];
                end
                pending_q <= 1'b0;
            end
            // A write after the commit keeps the flag set for the next boundary.
            if (we_i && (sel_i != SEL_NONE)) begin
                case (sel_i)
                    SEL_KP:  kp_sh_q[ch_i] <= data_i;
                    SEL_KI:  ki_sh_q[ch_i] <= data_i;
                    SEL_KD:  kd_sh_q[ch_i] <= data_i;
                    default: ;
                endcase
                pending_q <= 1'b1;
            end
        end
    end

    assign kp_o      = kp_ac_q[rd_ch_i];
    assign ki_o      = ki_ac_q[rd_ch_i];
    assign kd_o      = kd_ac_q[rd_ch_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/pid_sequencer.sv
// Slot-timed sequencer for the shared PID datapath: walks every channel
// through the 8 calculation states and commits coefficients per iteration.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int aw     = 1,
    parameter int cw     = PID_CW,
    parameter int dw     = 12,
    parameter int KP_DEF = 1,
    parameter int KI_DEF = 0,
    parameter int KD_DEF = 0
) (
    input  logic                  clk_pid,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [dw-1:0]         div,
    input  logic [(1<<aw)-1:0]    ch_en,
    input  logic                  cfg_we,
    input  logic [aw-1:0]         cfg_ch,
    input  logic [1:0]            cfg_sel,
    input  logic signed [cw-1:0]  cfg_data,
    output logic [aw-1:0]         a,
    output logic [PID_SW-1:0]     state,
    output logic                  calc,
    output logic                  ce,
    output logic signed [cw-1:0]  KP,
    output logic signed [cw-1:0]  KI,
    output logic signed [cw-1:0]  KD,
    output logic                  iter_done,
    output logic                  cfg_pending
);

    logic [dw-1:0]     timer_q, timer_d;
    logic [dw-1:0]     last_q, last_d;     // L-1 of the running slot
    logic [aw-1:0]     a_q, a_d;
    logic [PID_SW-1:0] state_q, state_d;
    logic              on_q, on_d;         // channel enable seen at slot start

    logic              run;
    logic [dw-1:0]     eff_div;
    logic              slot_end;
    logic              last_slot;

    // Strobes are gated by reset_n so they drop the moment reset asserts.
    assign run       = enable & reset_n;
    assign eff_div   = (div == '0) ? dw'(1) : div;
    // Timer 0 can never be the last cycle because a slot is at least 2 clocks.
    assign slot_end  = (timer_q != '0) && (timer_q == last_q);
    assign last_slot = (state_q == PID_SW'(PID_STATE_OUT)) && (a_q == '1);

    // Next-state for the slot timer and the (state, channel) position.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        timer_d = timer_q;
        last_d  = last_q;
        a_d     = a_q;
        state_d = state_q;
        on_d    = on_q;
        if (run) begin
            if (timer_q == '0) begin
                last_d = eff_div;
                on_d   = ch_en[a_q];
            end
            if (slot_end) begin
                timer_d = '0;
                a_d     = a_q + aw'(1);
                if (a_q == '1) begin
                    state_d = state_q + PID_SW'(1);
                end
            end else begin
                timer_d = timer_q + dw'(1);
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            last_q  <= dw'(1);
            a_q     <= '0;
            state_q <= '0;
            on_q    <= 1'b0;
        end else begin
            timer_q <= timer_d;
            last_q  <= last_d;
            a_q     <= a_d;
            state_q <= state_d;
            on_q    <= on_d;
        end
    end

    assign a         = a_q;
    assign state     = state_q;
    assign calc      = run && (timer_q == '0) && ch_en[a_q];
    assign ce        = run && (timer_q == dw'(1)) && (state_q == PID_SW'(PID_STATE_OUT)) && on_q;
    assign iter_done = run && slot_end && last_slot;

    pid_coef_bank #(
        .aw     (aw),
        .cw     (cw),
        .KP_DEF (KP_DEF),
        .KI_DEF (KI_DEF),
        .KD_DEF (KD_DEF)
    ) u_bank (
        .clk_pid   (clk_pid),
        .reset_n   (reset_n),
        .we_i      (cfg_we),
        .ch_i      (cfg_ch),
        .sel_i     (cfg_sel),
        .data_i    (cfg_data),
        .commit_i  (iter_done),
        .rd_ch_i   (a_q),
        .kp_o      (KP),
        .ki_o      (KI),
        .kd_o      (KD),
        .pending_o (cfg_pending)
    );

endmodule
